// File: rtl/ste_ext_joyport.sv
// STE extended joystick/paddle/lightpen port controller (bus regs at word addr[4:0]).
// Ports: CPU bus (din/dout/sel/addr/uds/lds/rw), joy_sel/data/fire, pad_*, lp_n/beam/vbl.
module ste_ext_joyport #(
  parameter int NUM_PORTS   = 2,
  parameter int DEBOUNCE_W  = 4,
  parameter int NUM_PADDLES = 4,
  parameter int PAD_W       = 8,
  parameter int LP_W        = 10,
  localparam int NPW = (NUM_PADDLES > 0) ? NUM_PADDLES : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic [15:0]            din,
  input  logic                   sel,
  input  logic [4:0]             addr,
  input  logic                   uds,
  input  logic                   lds,
  input  logic                   rw,
  output logic [15:0]            dout,
  output logic [4*NUM_PORTS-1:0] joy_sel,
  input  logic [4*NUM_PORTS-1:0] joy_data,
  input  logic [NUM_PORTS-1:0]   joy_fire,
  input  logic [NPW-1:0]         pad_cmp,
  input  logic                   pad_start,
  output logic [NPW-1:0]         pad_dump,
  input  logic                   lp_n,
  input  logic [LP_W-1:0]        beam_x,
  input  logic [LP_W-1:0]        beam_y,
  input  logic                   vbl
);

  localparam int NB = 5 * NUM_PORTS;
  localparam int ND = 4 * NUM_PORTS;
  localparam logic [DEBOUNCE_W-1:0] DB_MAX = '1;
  localparam logic [PAD_W-1:0] PAD_MAX = '1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHARGE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [NB-1:0] in_s1, in_s2, filt;
  logic [DEBOUNCE_W-1:0] db_cnt [NB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_s1 <= '1;
      in_s2 <= '1;
      filt  <= '1;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      in_s1 <= {joy_fire, joy_data};
      in_s2 <= in_s1;
      if (clk_en) begin
        for (int b = 0; b < NB; b++) begin
          if (in_s2[b] == filt[b]) begin
            db_cnt[b] <= '0;
          end else if (db_cnt[b] == DB_MAX) begin
            filt[b]   <= in_s2[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 1'b1;
          end
        end
      end
    end
  end

  logic wr_sel;
  assign wr_sel = sel & ~rw & clk_en & (addr == 5'h01);

  // Ports 0,1 live in the low byte, ports 2,3 in the high byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_sel <= '1;
    end else if (wr_sel) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((p < 2) ? lds : uds)
          joy_sel[4*p +: 4] <= din[4*p +: 4];
      end
    end
  end

  logic [NPW-1:0]   pc_s1, pc_s2;
  logic [1:0]       pad_state [NPW];
  logic [PAD_W-1:0] pad_cnt [NPW];
  logic [PAD_W-1:0] pad_res [NPW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_s1 <= '0;
      pc_s2 <= '0;
      for (int c = 0; c < NPW; c++) begin
        pad_state[c] <= S_IDLE;
        pad_cnt[c]   <= '0;
        pad_res[c]   <= '0;
      end
    end else begin
      pc_s1 <= pad_cmp;
      pc_s2 <= pc_s1;
      if (clk_en) begin
        for (int c = 0; c < NUM_PADDLES; c++) begin
          if (pad_start) begin
            pad_state[c] <= S_CHARGE;
            pad_cnt[c]   <= '0;
          end else if (pad_state[c] == S_CHARGE) begin
            if (pc_s2[c]) begin
              pad_res[c]   <= pad_cnt[c];
              pad_state[c] <= S_DONE;
            end else if (pad_cnt[c] == PAD_MAX) begin
              pad_res[c]   <= PAD_MAX;
              pad_state[c] <= S_DONE;
            end else begin
              pad_cnt[c] <= pad_cnt[c] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NPW; c++)
      pad_dump[c] = (pad_state[c] != S_CHARGE);
  end

  logic lp_s1, lp_s2, lp_q, lp_armed, lp_fall;
  logic [LP_W-1:0] lp_x, lp_y;

  assign lp_fall = lp_q & ~lp_s2;

  // A vbl in the same tick as a latch leaves the pen armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_s1    <= 1'b1;
      lp_s2    <= 1'b1;
      lp_q     <= 1'b1;
      lp_armed <= 1'b1;
      lp_x     <= '0;
      lp_y     <= '0;
    end else begin
      lp_s1 <= lp_n;
      lp_s2 <= lp_s1;
      if (clk_en) begin
        lp_q <= lp_s2;
        if (lp_fall && lp_armed) begin
          lp_x     <= beam_x;
          lp_y     <= beam_y;
          lp_armed <= vbl;
        end else if (vbl) begin
          lp_armed <= 1'b1;
        end
      end
    end
  end

  logic rd;
  assign rd = sel & rw;

  always_comb begin
    dout = '0;
    unique case (1'b1)
      rd && addr == 5'h00: begin
        dout = '1;
        dout[NUM_PORTS-1:0] = filt[NB-1:ND];
      end
      rd && addr == 5'h01: begin
        dout = '1;
        dout[ND-1:0] = filt[ND-1:0];
      end
      rd && addr[4:3] == 2'b01: begin
        for (int c = 0; c < NUM_PADDLES; c++)
          if (addr[2:0] == c[2:0])
            dout[PAD_W-1:0] = pad_res[c];
      end
      rd && addr == 5'h10: dout[LP_W-1:0] = lp_x;
      rd && addr == 5'h11: dout[LP_W-1:0] = lp_y;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ste_ext_joyport.sv
// Scoreboard bench for ste_ext_joyport: stimulus pushes expectations,
// a negedge monitor pops and compares dout / joy_sel / pad_dump.
module tb_ste_ext_joyport;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [15:0] din = '0;
  logic        sel = 1'b0;
  logic [4:0]  addr = '0;
  logic        uds = 1'b0;
  logic        lds = 1'b0;
  logic        rw = 1'b1;
  logic [15:0] dout;
  logic [7:0]  joy_sel;
  logic [7:0]  joy_data = 8'hFF;
  logic [1:0]  joy_fire = 2'b11;
  logic [3:0]  pad_cmp = '0;
  logic        pad_start = 1'b0;
  logic [3:0]  pad_dump;
  logic        lp_n = 1'b1;
  logic [9:0]  beam_x = '0;
  logic [9:0]  beam_y = '0;
  logic        vbl = 1'b0;

  ste_ext_joyport dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .din(din), .sel(sel), .addr(addr),
    .uds(uds), .lds(lds), .rw(rw), .dout(dout),
    .joy_sel(joy_sel), .joy_data(joy_data),
    .joy_fire(joy_fire), .pad_cmp(pad_cmp),
    .pad_start(pad_start), .pad_dump(pad_dump),
    .lp_n(lp_n), .beam_x(beam_x), .beam_y(beam_y),
    .vbl(vbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    sb_t e;
    logic [15:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        1:       act = {8'h00, joy_sel};
        2:       act = {12'h000, pad_dump};
        default: act = dout;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input int k, input logic [15:0] x, input string n);
    sb_t e;
    e.kind = k;
    e.exp  = x;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic chk(input int k, input logic [4:0] a,
                     input logic [15:0] x, input string n);
    @(posedge clk);
    #1;
    if (k == 0) begin
      sel  = 1'b1;
      rw   = 1'b1;
      addr = a;
    end
    push(k, x, n);
    @(negedge clk);
    #1;
    sel = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d,
                    input logic u, input logic l, input logic ce);
    @(posedge clk);
    #1;
    sel = 1'b1; rw = 1'b0; addr = a;
    din = d; uds = u; lds = l; clk_en = ce;
    @(posedge clk);
    #1;
    sel = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    @(posedge clk);
    #1;
    lp_n = 1'b0;
    ticks(5);
    lp_n = 1'b1;
    ticks(4);
  endtask

  initial begin
    ticks(3);
    reset_n = 1'b1;
    ticks(2);

    chk(0, 5'h00, 16'hFFFF, "rst_fire");
    chk(0, 5'h01, 16'hFFFF, "rst_data");
    chk(1, 5'h00, 16'h00FF, "rst_joysel");
    chk(2, 5'h00, 16'h000F, "rst_dump");

    joy_fire[0] = 1'b0;
    ticks(15);
    joy_fire[0] = 1'b1;
    ticks(6);
    chk(0, 5'h00, 16'hFFFF, "fire_15");
    joy_fire[0] = 1'b0;
    ticks(16);
    joy_fire[0] = 1'b1;
    ticks(1);
    chk(0, 5'h00, 16'hFFFE, "fire_16");
    ticks(24);
    chk(0, 5'h00, 16'hFFFF, "fire_rel");

    joy_data = 8'hF5;
    ticks(22);
    chk(0, 5'h01, 16'hFFF5, "data_f5");
    joy_data = 8'h3F;
    ticks(22);
    chk(0, 5'h01, 16'hFF3F, "data_3f");
    joy_data = 8'hFF;
    ticks(22);

    wr(5'h01, 16'h00A5, 1'b0, 1'b1, 1'b1);
    chk(1, 5'h00, 16'h00A5, "sel_lds");
    wr(5'h01, 16'h3C00, 1'b1, 1'b0, 1'b1);
    chk(1, 5'h00, 16'h00A5, "sel_uds");
    wr(5'h01, 16'h0011, 1'b0, 1'b1, 1'b0);
    chk(1, 5'h00, 16'h00A5, "sel_noen");
    wr(5'h00, 16'h0022, 1'b1, 1'b1, 1'b1);
    chk(1, 5'h00, 16'h00A5, "sel_addr0");

    @(posedge clk);
    #1;
    pad_start = 1'b1;
    ticks(1);
    pad_start = 1'b0;
    ticks(35);
    pad_cmp[1] = 1'b1;
    ticks(6);
    chk(2, 5'h00, 16'h0002, "dump_ch1");
    ticks(270);
    chk(2, 5'h00, 16'h000F, "dump_done");
    chk(0, 5'h09, 16'h0025, "pad1");
    chk(0, 5'h08, 16'h00FF, "pad0_sat");
    chk(0, 5'h0B, 16'h00FF, "pad3_sat");
    chk(0, 5'h0C, 16'h0000, "pad4_abs");
    pad_cmp[1] = 1'b0;

    beam_x = 10'd300;
    beam_y = 10'd120;
    strobe();
    chk(0, 5'h10, 16'd300, "lp_x1");
    chk(0, 5'h11, 16'd120, "lp_y1");
    beam_x = 10'd500;
    beam_y = 10'd200;
    strobe();
    chk(0, 5'h10, 16'd300, "lp_x_hold");
    chk(0, 5'h11, 16'd120, "lp_y_hold");
    @(posedge clk);
    #1;
    vbl = 1'b1;
    ticks(1);
    vbl = 1'b0;
    beam_x = 10'd7;
    beam_y = 10'd9;
    strobe();
    chk(0, 5'h10, 16'd7, "lp_x2");
    chk(0, 5'h11, 16'd9, "lp_y2");

    @(posedge clk);
    #1;
    pad_start = 1'b1;
    ticks(1);
    pad_start = 1'b0;
    ticks(8);
    chk(2, 5'h00, 16'h0000, "dump_chg");
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    sel  = 1'b1;
    rw   = 1'b1;
    addr = 5'h09;
    push(2, 16'h000F, "arst_dump");
    push(1, 16'h00FF, "arst_sel");
    push(0, 16'h0000, "arst_pad1");
    @(negedge clk);
    #1;
    sel = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
    chk(0, 5'h10, 16'h0000, "arst_lpx");
    chk(0, 5'h08, 16'h0000, "arst_pad0");

    ticks(3);
    if (sbq.size() != 0) begin
      $display("FAIL sb_drain: got %0d want 0", sbq.size());
      sbq.delete();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
